// File: rtl/fat32_pkg.sv
// Shared constants and types for the FAT32 boot-sector parser: field offsets,
// partition types, error codes and FSM state encoding.
package fat32_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StCheck
  } state_e;

  localparam int unsigned OffBps      = 32'h00B;
  localparam int unsigned OffSpc      = 32'h00D;
  localparam int unsigned OffRsv      = 32'h00E;
  localparam int unsigned OffNumFats  = 32'h010;
  localparam int unsigned OffFatSize  = 32'h024;
  localparam int unsigned OffRootClus = 32'h02C;
  localparam int unsigned OffPartType = 32'h1C2;
  localparam int unsigned OffPartLba  = 32'h1C6;
  localparam int unsigned OffSig      = 32'h1FE;

  localparam logic [7:0] PartTypeFat32Chs = 8'h0B;
  localparam logic [7:0] PartTypeFat32Lba = 8'h0C;

  localparam logic [7:0]  Sig0        = 8'h55;
  localparam logic [7:0]  Sig1        = 8'hAA;
  localparam logic [15:0] BpsRequired = 16'h0200;

  localparam logic [2:0] ErrOk    = 3'd0;
  localparam logic [2:0] ErrSig   = 3'd1;
  localparam logic [2:0] ErrType  = 3'd2;
  localparam logic [2:0] ErrBps   = 3'd3;
  localparam logic [2:0] ErrShort = 3'd4;
  localparam logic [2:0] ErrLong  = 3'd5;

  function automatic logic in_field(logic [31:0] idx, int unsigned base, int unsigned len);
    return (idx >= base) && (idx < base + len);
  endfunction

  // Bit offset of the byte lane for a 32-bit little-endian field.
  function automatic logic [4:0] lane_lsb(logic [31:0] idx, int unsigned base);
    logic [31:0] diff;
    diff = idx - base;
    return {diff[1:0], 3'b000};
  endfunction

endpackage

// File: rtl/boot_byte_counter.sv
// Saturating byte counter for one block; flags any strobe beyond BLOCK_BYTES.
module boot_byte_counter #(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             incr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  logic [CNT_W-1:0] count_d, count_q;
  logic             ovf_d, ovf_q;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (incr_i) begin
      if (count_q == CNT_W'(BLOCK_BYTES)) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/fat32_boot_parser.sv
// Parses a 512-byte MBR or FAT32 volume boot record from the SD byte stream and
// reports partition LBA or BPB geometry plus a validation result.
module fat32_boot_parser
  import fat32_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned CNT_W       = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [7:0]  in_byte,
  input  logic        byte_strobe,
  input  logic        block_done,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  error_code,
  output logic [31:0] partition_lba,
  output logic [15:0] bytes_per_sector,
  output logic [7:0]  sectors_per_cluster,
  output logic [15:0] reserved_sectors,
  output logic [7:0]  num_fats,
  output logic [31:0] fat_size,
  output logic [31:0] root_cluster
);

  state_e      state_d, state_q;
  logic        mode_d, mode_q;
  logic        busy_d, busy_q;
  logic        done_d, done_q;
  logic        error_d, error_q;
  logic [2:0]  code_d, code_q;
  logic [31:0] lba_d, lba_q;
  logic [15:0] bps_d, bps_q;
  logic [7:0]  spc_d, spc_q;
  logic [15:0] rsv_d, rsv_q;
  logic [7:0]  nfat_d, nfat_q;
  logic [31:0] fsz_d, fsz_q;
  logic [31:0] root_d, root_q;
  logic [7:0]  ptype_d, ptype_q;
  logic [7:0]  sig0_d, sig0_q;
  logic [7:0]  sig1_d, sig1_q;

  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             cnt_clear, cnt_incr;
  logic [31:0]      idx;

  assign cnt_clear = (state_q == StIdle) && start;
  assign cnt_incr  = (state_q == StCollect) && byte_strobe;
  assign idx       = 32'(count);

  boot_byte_counter #(
    .BLOCK_BYTES(BLOCK_BYTES),
    .CNT_W      (CNT_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (cnt_clear),
    .incr_i    (cnt_incr),
    .count_o   (count),
    .overflow_o(overflow)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    code_d  = code_q;
    lba_d   = lba_q;
    bps_d   = bps_q;
    spc_d   = spc_q;
    rsv_d   = rsv_q;
    nfat_d  = nfat_q;
    fsz_d   = fsz_q;
    root_d  = root_q;
    ptype_d = ptype_q;
    sig0_d  = sig0_q;
    sig1_d  = sig1_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCollect;
          mode_d  = mode;
          busy_d  = 1'b1;
          error_d = 1'b0;
          code_d  = ErrOk;
          lba_d   = '0;
          bps_d   = '0;
          spc_d   = '0;
          rsv_d   = '0;
          nfat_d  = '0;
          fsz_d   = '0;
          root_d  = '0;
          ptype_d = '0;
          sig0_d  = '0;
          sig1_d  = '0;
        end
      end
      StCollect: begin
        if (byte_strobe) begin
          if (mode_q) begin
            if (idx == OffBps)       bps_d[7:0]   = in_byte;
            if (idx == OffBps + 1)   bps_d[15:8]  = in_byte;
            if (idx == OffSpc)       spc_d        = in_byte;
            if (idx == OffRsv)       rsv_d[7:0]   = in_byte;
            if (idx == OffRsv + 1)   rsv_d[15:8]  = in_byte;
            if (idx == OffNumFats)   nfat_d       = in_byte;
            if (in_field(idx, OffFatSize, 4))  fsz_d[lane_lsb(idx, OffFatSize) +: 8]  = in_byte;
            if (in_field(idx, OffRootClus, 4)) root_d[lane_lsb(idx, OffRootClus) +: 8] = in_byte;
          end else begin
            if (idx == OffPartType) ptype_d = in_byte;
            if (in_field(idx, OffPartLba, 4)) lba_d[lane_lsb(idx, OffPartLba) +: 8] = in_byte;
          end
          if (idx == OffSig)     sig0_d = in_byte;
          if (idx == OffSig + 1) sig1_d = in_byte;
        end
        if (block_done) state_d = StCheck;
      end
      StCheck: begin
        // Counter already includes a byte that arrived alongside block_done.
        if (count < CNT_W'(BLOCK_BYTES)) begin
          code_d = ErrShort;
        end else if (overflow) begin
          code_d = ErrLong;
        end else if (sig0_q != Sig0 || sig1_q != Sig1) begin
          code_d = ErrSig;
        end else if (!mode_q && ptype_q != PartTypeFat32Chs && ptype_q != PartTypeFat32Lba) begin
          code_d = ErrType;
        end else if (mode_q && bps_q != BpsRequired) begin
          code_d = ErrBps;
        end else begin
          code_d = ErrOk;
        end
        error_d = (code_d != ErrOk);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= ErrOk;
      lba_q   <= '0;
      bps_q   <= '0;
      spc_q   <= '0;
      rsv_q   <= '0;
      nfat_q  <= '0;
      fsz_q   <= '0;
      root_q  <= '0;
      ptype_q <= '0;
      sig0_q  <= '0;
      sig1_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
      lba_q   <= lba_d;
      bps_q   <= bps_d;
      spc_q   <= spc_d;
      rsv_q   <= rsv_d;
      nfat_q  <= nfat_d;
      fsz_q   <= fsz_d;
      root_q  <= root_d;
      ptype_q <= ptype_d;
      sig0_q  <= sig0_d;
      sig1_q  <= sig1_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;
  assign error_code          = code_q;
  assign partition_lba       = lba_q;
  assign bytes_per_sector    = bps_q;
  assign sectors_per_cluster = spc_q;
  assign reserved_sectors    = rsv_q;
  assign num_fats            = nfat_q;
  assign fat_size            = fsz_q;
  assign root_cluster        = root_q;

endmodule

// File: tb/tb_fat32_boot_parser.sv
// Directed self-checking bench for fat32_boot_parser: MBR and BPB parses,
// error priority, block length errors, mid-block reset and ignored restart.
module tb_fat32_boot_parser;

  logic        clk = 1'b0;
  logic        rst, start, mode, byte_strobe, block_done;
  logic [7:0]  in_byte;
  logic        busy, done, error;
  logic [2:0]  error_code;
  logic [31:0] partition_lba, fat_size, root_cluster;
  logic [15:0] bytes_per_sector, reserved_sectors;
  logic [7:0]  sectors_per_cluster, num_fats;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] blk [0:1023];
  logic       seen_done;

  always #5 clk = ~clk;

  fat32_boot_parser u_dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .mode               (mode),
    .in_byte            (in_byte),
    .byte_strobe        (byte_strobe),
    .block_done         (block_done),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .error_code         (error_code),
    .partition_lba      (partition_lba),
    .bytes_per_sector   (bytes_per_sector),
    .sectors_per_cluster(sectors_per_cluster),
    .reserved_sectors   (reserved_sectors),
    .num_fats           (num_fats),
    .fat_size           (fat_size),
    .root_cluster       (root_cluster)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put32(input int off, input logic [31:0] val);
    for (int k = 0; k < 4; k++) blk[off + k] = val[8*k +: 8];
  endtask

  task automatic blank_with_sig();
    for (int i = 0; i < 1024; i++) blk[i] = 8'h00;
    blk[16'h1FE] = 8'h55;
    blk[16'h1FF] = 8'hAA;
  endtask

  // MBR with BPB-looking bytes that must not reach the BPB outputs.
  task automatic mbr_block(input logic [7:0] ptype);
    blank_with_sig();
    blk[16'h1C2] = ptype;
    put32(16'h1C6, 32'h0000_0800);
    blk[16'h00B] = 8'h00;
    blk[16'h00C] = 8'h02;
  endtask

  // BPB with MBR-looking bytes that must not reach partition_lba.
  task automatic bpb_block();
    blank_with_sig();
    blk[16'h00B] = 8'h00;
    blk[16'h00C] = 8'h02;
    blk[16'h00D] = 8'd8;
    blk[16'h00E] = 8'd32;
    blk[16'h00F] = 8'd0;
    blk[16'h010] = 8'd2;
    put32(16'h024, 32'h0000_03C1);
    put32(16'h02C, 32'h0000_0002);
    blk[16'h1C2] = 8'h07;
    put32(16'h1C6, 32'hDEAD_BEEF);
  endtask

  task automatic pulse_start(input logic m);
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 1'b0;
  endtask

  // Streams n bytes; joint puts block_done on the last byte; mid pulses start
  // with the opposite mode at that byte index (-1 for none).
  task automatic run_block(input string tag, input logic m, input int n, input logic joint,
                           input int mid);
    pulse_start(m);
    check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      in_byte     = blk[i];
      byte_strobe = 1'b1;
      block_done  = joint && (i == n - 1);
      if (i == mid) begin
        start = 1'b1;
        mode  = ~m;
      end
      @(posedge clk); #1;
      byte_strobe = 1'b0;
      block_done  = 1'b0;
      start       = 1'b0;
      mode        = 1'b0;
    end
    if (!joint) begin
      block_done = 1'b1;
      @(posedge clk); #1;
      block_done = 1'b0;
    end
    check({tag, "_done_early"}, {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_done_drop(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; in_byte = 8'h00;
    byte_strobe = 1'b0; block_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_code", {29'd0, error_code}, 32'd0);
    check("rst_lba", partition_lba, 32'd0);
    check("rst_root", root_cluster, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Good MBR, type 0x0C
    mbr_block(8'h0C);
    run_block("mbr_ok", 1'b0, 512, 1'b0, -1);
    check("mbr_ok_error", {31'd0, error}, 32'd0);
    check("mbr_ok_code", {29'd0, error_code}, 32'd0);
    check("mbr_ok_lba", partition_lba, 32'h0000_0800);
    check("mbr_ok_bps_untouched", {16'd0, bytes_per_sector}, 32'd0);
    check_done_drop("mbr_ok");

    // Good BPB
    bpb_block();
    run_block("bpb_ok", 1'b1, 512, 1'b0, -1);
    check("bpb_error", {31'd0, error}, 32'd0);
    check("bpb_code", {29'd0, error_code}, 32'd0);
    check("bpb_bps", {16'd0, bytes_per_sector}, 32'h0200);
    check("bpb_spc", {24'd0, sectors_per_cluster}, 32'd8);
    check("bpb_rsv", {16'd0, reserved_sectors}, 32'd32);
    check("bpb_nfats", {24'd0, num_fats}, 32'd2);
    check("bpb_fatsz", fat_size, 32'h0000_03C1);
    check("bpb_root", root_cluster, 32'd2);
    check("bpb_lba_cleared", partition_lba, 32'd0);

    // BPB with wrong bytes_per_sector
    bpb_block();
    blk[16'h00C] = 8'h04;
    run_block("bpb_bad", 1'b1, 512, 1'b0, -1);
    check("bpb_bad_code", {29'd0, error_code}, 32'd3);

    // MBR with unsupported type, then bad signature on top of it
    mbr_block(8'h07);
    run_block("mbr_type", 1'b0, 512, 1'b0, -1);
    check("mbr_type_error", {31'd0, error}, 32'd1);
    check("mbr_type_code", {29'd0, error_code}, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    check("mbr_type_error_hold", {31'd0, error}, 32'd1);
    blk[16'h1FF] = 8'hAB;
    run_block("mbr_sig", 1'b0, 512, 1'b0, -1);
    check("mbr_sig_code", {29'd0, error_code}, 32'd1);

    // Short and long blocks
    mbr_block(8'h0C);
    run_block("short", 1'b0, 300, 1'b0, -1);
    check("short_code", {29'd0, error_code}, 32'd4);
    run_block("long", 1'b0, 514, 1'b0, -1);
    check("long_code", {29'd0, error_code}, 32'd5);
    check("long_error", {31'd0, error}, 32'd1);

    // Last byte coincident with block_done
    run_block("joint", 1'b0, 512, 1'b1, -1);
    check("joint_code", {29'd0, error_code}, 32'd0);
    check("joint_error", {31'd0, error}, 32'd0);
    check("joint_lba", partition_lba, 32'h0000_0800);

    // Reset after 100 bytes of a BPB
    bpb_block();
    pulse_start(1'b1);
    for (int i = 0; i < 100; i++) begin
      in_byte     = blk[i];
      byte_strobe = 1'b1;
      @(posedge clk); #1;
      byte_strobe = 1'b0;
    end
    check("mid_bps_captured", {16'd0, bytes_per_sector}, 32'h0200);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_bps", {16'd0, bytes_per_sector}, 32'd0);
    check("mrst_root", root_cluster, 32'd0);
    check("mrst_spc", {24'd0, sectors_per_cluster}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      byte_strobe = 1'b1;
      block_done  = (i == 3);
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    byte_strobe = 1'b0;
    block_done  = 1'b0;
    check("mrst_no_done", {31'd0, seen_done}, 32'd0);
    check("mrst_idle_busy", {31'd0, busy}, 32'd0);

    // Clean MBR after reset, with an ignored start mid-block
    mbr_block(8'h0B);
    run_block("restart", 1'b0, 512, 1'b0, 200);
    check("restart_code", {29'd0, error_code}, 32'd0);
    check("restart_lba", partition_lba, 32'h0000_0800);
    check("restart_bps", {16'd0, bytes_per_sector}, 32'd0);
    check_done_drop("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
